// File: rtl/formant_frame_scheduler_pkg.sv
// formant_pkg
//   Shared definitions for the formant frame scheduler.
//   - BIT_WIDTH_DEF / I_DEF / TIMEOUT_DEF / CNT_WIDTH_DEF: default parameter values
//   - sched_state_t: read-side FSM states (IDLE, STREAM, WAIT_DONE)
//   - wr_mode_t:     write-side frame capture modes
package formant_pkg;

    localparam int BIT_WIDTH_DEF = 32;
    localparam int I_DEF         = 160;
    localparam int TIMEOUT_DEF   = 1_000_000;
    localparam int CNT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2
    } sched_state_t;

    // WR_IDLE    : between frames, next in_valid starts a frame
    // WR_FILL    : writing bins of an accepted frame into the free slot
    // WR_DROP    : no slot was free at frame start, ignoring bins up to in_last
    // WR_DISCARD : frame overran I bins, ignoring bins up to in_last
    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_FILL    = 2'd1,
        WR_DROP    = 2'd2,
        WR_DISCARD = 2'd3
    } wr_mode_t;

endpackage

// File: rtl/formant_frame_scheduler_ram.sv
// xilinx_true_dual_port_read_first_1_clock_ram
//   True dual-port, read-first block RAM on a single clock.
//   Ports:
//     clka              : clock shared by both ports
//     addra/dina/wea/ena: port A address, write data, write enable, port enable
//     addrb/dinb/web/enb: port B address, write data, write enable, port enable
//     douta/doutb       : read data; 1-cycle latency for "LOW_LATENCY",
//                         2-cycle latency for any other RAM_PERFORMANCE value
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int    RAM_WIDTH       = 32,
    parameter int    RAM_DEPTH       = 320,
    parameter string RAM_PERFORMANCE = "LOW_LATENCY"
) (
    input  logic                         clka,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic [RAM_WIDTH-1:0]         dinb,
    input  logic                         wea,
    input  logic                         web,
    input  logic                         ena,
    input  logic                         enb,
    output logic [RAM_WIDTH-1:0]         douta,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] r_data_a;
    logic [RAM_WIDTH-1:0] r_data_b;

    // Both ports share one process so the array has a single driver.
    // Read-first: the read register captures the old contents on a write.
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                r_mem[addra] <= dina;
            end
            r_data_a <= r_mem[addra];
        end
        if (enb) begin
            if (web) begin
                r_mem[addrb] <= dinb;
            end
            r_data_b <= r_mem[addrb];
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
            assign douta = r_data_a;
            assign doutb = r_data_b;
        end else begin : g_high_performance
            logic [RAM_WIDTH-1:0] r_out_a;
            logic [RAM_WIDTH-1:0] r_out_b;
            always_ff @(posedge clka) begin
                r_out_a <= r_data_a;
                r_out_b <= r_data_b;
            end
            assign douta = r_out_a;
            assign doutb = r_out_b;
        end
    endgenerate

endmodule

// File: rtl/formant_frame_scheduler.sv
// formant_frame_scheduler
//   Captures FFT magnitude frames of I bins into a two-slot ping-pong buffer and
//   replays each committed frame to the formant engine as one contiguous I-cycle
//   burst, then waits for the engine's completion pulse under a watchdog.
//   Ports:
//     clk_in, rst_in          : clock, asynchronous active-high reset
//     in_valid/in_data/in_last: FFT bin stream (no backpressure)
//     eng_valid/eng_data      : bin burst to the engine (zero outside bursts)
//     eng_done                : engine completion pulse
//     eng_abort               : one-cycle pulse on watchdog expiry (engine reset)
//     busy                    : read side not in IDLE
//     slots_full              : per-slot committed flags
//     drop_count              : frames dropped because no slot was free
//     err_count               : malformed frames discarded
//     timeout_count           : watchdog aborts
//   All counters saturate.
module formant_frame_scheduler
    import formant_pkg::*;
#(
    parameter int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int I         = I_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 in_valid,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic                 in_last,
    output logic                 eng_valid,
    output logic [BIT_WIDTH-1:0] eng_data,
    input  logic                 eng_done,
    output logic                 eng_abort,
    output logic                 busy,
    output logic [1:0]           slots_full,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] timeout_count
);

    localparam int ADDR_W = $clog2(2 * I);
    localparam int IDX_W  = (I > 1) ? $clog2(I) : 1;
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(I - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic [ADDR_W-1:0] slot_addr(input logic slot,
                                                    input logic [IDX_W-1:0] idx);
        return (slot ? ADDR_W'(I) : ADDR_W'(0)) + ADDR_W'(idx);
    endfunction

    // ------------------------------------------------------------------
    // Write-side state
    // ------------------------------------------------------------------
    wr_mode_t               r_wr_mode;
    logic                   r_wr_ptr;
    logic [IDX_W-1:0]       r_bin_idx;
    logic [1:0]             r_full;
    logic [CNT_WIDTH-1:0]   r_drop_count;
    logic [CNT_WIDTH-1:0]   r_err_count;

    // ------------------------------------------------------------------
    // Read-side state
    // ------------------------------------------------------------------
    sched_state_t           r_state;
    sched_state_t           w_next_state;
    logic                   r_rd_ptr;
    logic [IDX_W-1:0]       r_rd_idx;
    logic [WD_W-1:0]        r_wd;
    logic                   r_eng_valid;
    logic                   r_eng_abort;
    logic [CNT_WIDTH-1:0]   r_timeout_count;

    // ------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------
    logic                   w_slot_clear;
    logic                   w_timeout;
    logic [1:0]             w_clear_mask;
    logic [1:0]             w_full_eff;
    logic                   w_frame_start;
    logic                   w_drop;
    logic                   w_wr_en;
    logic [IDX_W-1:0]       w_wr_idx;
    logic                   w_commit;
    logic [1:0]             w_commit_mask;
    logic                   w_err;
    logic [ADDR_W-1:0]      w_wr_addr;
    logic [ADDR_W-1:0]      w_rd_addr;
    logic                   w_rd_en;
    logic [BIT_WIDTH-1:0]   w_ram_doutb;
    logic [BIT_WIDTH-1:0]   w_ram_douta_unused;

    // A slot being released this cycle already counts as free for a frame
    // starting in the same cycle.
    assign w_clear_mask  = w_slot_clear ? (r_rd_ptr ? 2'b10 : 2'b01) : 2'b00;
    assign w_full_eff    = r_full & ~w_clear_mask;

    // Slots fill and drain in strict alternation, so the write-pointer slot is
    // the free one whenever any slot is free.
    assign w_frame_start = in_valid && (r_wr_mode == WR_IDLE);
    assign w_drop        = w_frame_start && w_full_eff[r_wr_ptr];
    assign w_wr_en       = in_valid && ((w_frame_start && !w_full_eff[r_wr_ptr]) ||
                                        (r_wr_mode == WR_FILL));
    assign w_wr_idx      = w_frame_start ? '0 : r_bin_idx;
    assign w_wr_addr     = slot_addr(r_wr_ptr, w_wr_idx);

    assign w_commit      = w_wr_en && in_last && (w_wr_idx == LAST_IDX);
    assign w_commit_mask = w_commit ? (r_wr_ptr ? 2'b10 : 2'b01) : 2'b00;
    // Short frame (early in_last) or overrun (bin I-1 without in_last).
    assign w_err         = w_wr_en && (in_last ? (w_wr_idx != LAST_IDX)
                                               : (w_wr_idx == LAST_IDX));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_mode    <= WR_IDLE;
            r_wr_ptr     <= 1'b0;
            r_bin_idx    <= '0;
            r_full       <= 2'b00;
            r_drop_count <= '0;
            r_err_count  <= '0;
        end else begin
            r_full <= w_full_eff | w_commit_mask;
            if (w_commit) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_err) begin
                r_err_count <= sat_inc(r_err_count);
            end
            if (w_drop) begin
                r_drop_count <= sat_inc(r_drop_count);
            end

            if (w_drop) begin
                r_wr_mode <= in_last ? WR_IDLE : WR_DROP;
            end else if (w_wr_en) begin
                if (in_last) begin
                    r_wr_mode <= WR_IDLE;
                end else if (w_wr_idx == LAST_IDX) begin
                    r_wr_mode <= WR_DISCARD;
                end else begin
                    r_wr_mode <= WR_FILL;
                    r_bin_idx <= w_wr_idx + IDX_W'(1);
                end
            end else if (in_valid && in_last) begin
                // End of a dropped or overrun frame.
                r_wr_mode <= WR_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_slot_clear = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                // Looking at the commit in flight lets the burst start the
                // cycle right after in_last.
                if (r_full[r_rd_ptr] || (w_commit && (r_wr_ptr == r_rd_ptr))) begin
                    w_next_state = STREAM;
                end
            end
            STREAM: begin
                if (r_rd_idx == LAST_IDX) begin
                    w_next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // eng_done takes priority over a coincident watchdog expiry.
                if (eng_done) begin
                    w_slot_clear = 1'b1;
                    w_next_state = IDLE;
                end else if (r_wd == WD_LAST) begin
                    w_slot_clear = 1'b1;
                    w_timeout    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_rd_en   = (r_state == STREAM);
    assign w_rd_addr = slot_addr(r_rd_ptr, r_rd_idx);

    // ------------------------------------------------------------------
    // Read FSM: state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state         <= IDLE;
            r_rd_ptr        <= 1'b0;
            r_rd_idx        <= '0;
            r_wd            <= '0;
            r_eng_valid     <= 1'b0;
            r_eng_abort     <= 1'b0;
            r_timeout_count <= '0;
        end else begin
            r_state     <= w_next_state;
            // RAM data appears one cycle after the address, aligned with this.
            r_eng_valid <= w_rd_en;
            r_eng_abort <= w_timeout;

            if (r_state == STREAM) begin
                r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + IDX_W'(1);
                r_wd     <= '0;
            end else if (r_state == WAIT_DONE) begin
                r_wd <= r_wd + WD_W'(1);
            end

            if (w_slot_clear) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_timeout) begin
                r_timeout_count <= sat_inc(r_timeout_count);
            end
        end
    end

    xilinx_true_dual_port_read_first_1_clock_ram #(
        .RAM_WIDTH       (BIT_WIDTH),
        .RAM_DEPTH       (2 * I),
        .RAM_PERFORMANCE ("LOW_LATENCY")
    ) u_frame_buf (
        .clka  (clk_in),
        .addra (w_wr_addr),
        .addrb (w_rd_addr),
        .dina  (in_data),
        .dinb  ('0),
        .wea   (w_wr_en),
        .web   (1'b0),
        .ena   (w_wr_en),
        .enb   (w_rd_en),
        .douta (w_ram_douta_unused),
        .doutb (w_ram_doutb)
    );

    assign eng_valid     = r_eng_valid;
    // Gate with the registered valid so data is zero outside bursts and
    // drops together with eng_valid on reset.
    assign eng_data      = r_eng_valid ? w_ram_doutb : '0;
    assign eng_abort     = r_eng_abort;
    assign busy          = (r_state != IDLE);
    assign slots_full    = r_full;
    assign drop_count    = r_drop_count;
    assign err_count     = r_err_count;
    assign timeout_count = r_timeout_count;

endmodule

// File: tb/tb_formant_frame_scheduler.sv
module tb_formant_frame_scheduler;

    localparam int BW = 32;
    localparam int NB = 160;
    localparam int TO = 1000;
    localparam int CW = 16;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          in_valid = 1'b0;
    logic [BW-1:0] in_data  = '0;
    logic          in_last  = 1'b0;
    logic          eng_done = 1'b0;
    logic          eng_valid;
    logic [BW-1:0] eng_data;
    logic          eng_abort;
    logic          busy;
    logic [1:0]    slots_full;
    logic [CW-1:0] drop_count;
    logic [CW-1:0] err_count;
    logic [CW-1:0] timeout_count;

    always #5 clk = ~clk;

    formant_frame_scheduler #(
        .BIT_WIDTH (BW),
        .I         (NB),
        .TIMEOUT   (TO),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .eng_valid     (eng_valid),
        .eng_data      (eng_data),
        .eng_done      (eng_done),
        .eng_abort     (eng_abort),
        .busy          (busy),
        .slots_full    (slots_full),
        .drop_count    (drop_count),
        .err_count     (err_count),
        .timeout_count (timeout_count)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t_last   = 0;
    int abort_cnt = 0;
    int abort_cyc = -1;
    int idle_bad  = 0;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] obs_q[$];
    int            obs_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (eng_valid === 1'b1) begin
            obs_q.push_back(eng_data);
            obs_cyc_q.push_back(cyc);
        end else if (eng_data !== '0) begin
            idle_bad++;
        end
        if (eng_abort === 1'b1) begin
            abort_cnt++;
            abort_cyc = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "global timeout");
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
        abort_cnt = 0;
        abort_cyc = -1;
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        eng_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        clear_sb();
    endtask

    // Bin k of frame 'seed' carries (seed << 16) | k. last_at < 0 means no in_last.
    task automatic send_frame(input int n, input int last_at, input int seed,
                              input bit expect_stream);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = (BW'(seed) << 16) | BW'(k);
            in_last  = (k == last_at);
            if (expect_stream) exp_q.push_back(in_data);
            if (k == last_at) t_last = cyc;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_until(input int target);
        int guard = 0;
        while (cyc < target && guard < 5000) begin
            tick();
            guard++;
        end
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic pulse_done();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
    endtask

    function automatic int stream_mismatches();
        int bad = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= obs_q.size()) bad++;
            else if (obs_q[i] !== exp_q[i]) bad++;
        end
        return bad;
    endfunction

    function automatic int first_cyc();
        return (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : -1;
    endfunction

    function automatic int last_cyc();
        return (obs_cyc_q.size() > 0) ? obs_cyc_q[obs_cyc_q.size() - 1] : -1;
    endfunction

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++; if (eng_valid !== 1'b0) begin failures++; $display("FAIL reset_eng_valid: got %0b expected 0", eng_valid); end
        checks++; if (eng_data !== '0) begin failures++; $display("FAIL reset_eng_data: got %0h expected 0", eng_data); end
        checks++; if (eng_abort !== 1'b0) begin failures++; $display("FAIL reset_eng_abort: got %0b expected 0", eng_abort); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (slots_full !== 2'b00) begin failures++; $display("FAIL reset_slots_full: got %b expected 00", slots_full); end
        checks++; if (drop_count !== '0 || err_count !== '0 || timeout_count !== '0) begin
            failures++;
            $display("FAIL reset_counters: got drop=%0d err=%0d to=%0d expected 0/0/0",
                     drop_count, err_count, timeout_count);
        end
        apply_reset();
    endtask

    task automatic test_single_frame();
        int t;
        apply_reset();
        send_frame(NB, NB - 1, 1, 1'b1);
        t = t_last;
        wait_until(t + 500);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_before_done: got %0b expected 1 at cyc %0d", busy, cyc); end
        pulse_done();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after_done: got %0b expected 0 at cyc %0d (t+501=%0d)", busy, cyc, t + 501); end
        checks++; if (obs_q.size() != NB) begin failures++; $display("FAIL single_burst_len: got %0d expected %0d", obs_q.size(), NB); end
        checks++; if (first_cyc() != t + 2) begin failures++; $display("FAIL single_first_valid: got cyc %0d expected %0d", first_cyc(), t + 2); end
        checks++; if (last_cyc() != t + 161) begin failures++; $display("FAIL single_last_valid: got cyc %0d expected %0d", last_cyc(), t + 161); end
        checks++; if (stream_mismatches() != 0) begin failures++; $display("FAIL single_data: got %0d wrong bins expected 0", stream_mismatches()); end
        checks++; if (slots_full !== 2'b00) begin failures++; $display("FAIL single_slots_after: got %b expected 00", slots_full); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        send_frame(NB, NB - 1, 2, 1'b1);
        send_frame(NB, NB - 1, 3, 1'b1);
        send_frame(NB, NB - 1, 4, 1'b0);
        tick();
        checks++; if (drop_count !== CW'(1)) begin failures++; $display("FAIL b2b_drop_count: got %0d expected 1", drop_count); end
        checks++; if (err_count !== '0) begin failures++; $display("FAIL b2b_err_count: got %0d expected 0", err_count); end
        checks++; if (slots_full !== 2'b11) begin failures++; $display("FAIL b2b_slots_full: got %b expected 11", slots_full); end
        checks++; if (obs_q.size() != NB) begin failures++; $display("FAIL b2b_first_burst_len: got %0d expected %0d", obs_q.size(), NB); end
        pulse_done();
        wait_obs(2 * NB, 400);
        pulse_done();
        tick();
        checks++; if (obs_q.size() != 2 * NB) begin failures++; $display("FAIL b2b_total_len: got %0d expected %0d", obs_q.size(), 2 * NB); end
        checks++; if (stream_mismatches() != 0) begin failures++; $display("FAIL b2b_data: got %0d wrong bins expected 0", stream_mismatches()); end
        checks++; if (busy !== 1'b0 || slots_full !== 2'b00) begin
            failures++;
            $display("FAIL b2b_final_state: got busy=%0b slots=%b expected 0/00", busy, slots_full);
        end
    endtask

    task automatic test_short_frame();
        apply_reset();
        send_frame(100, 99, 5, 1'b0);
        repeat (10) tick();
        checks++; if (err_count !== CW'(1)) begin failures++; $display("FAIL short_err_count: got %0d expected 1", err_count); end
        checks++; if (slots_full !== 2'b00) begin failures++; $display("FAIL short_slots_full: got %b expected 00", slots_full); end
        checks++; if (obs_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL short_no_stream: got %0d bins busy=%0b expected 0/0", obs_q.size(), busy);
        end
    endtask

    task automatic test_long_frame();
        apply_reset();
        send_frame(170, 169, 6, 1'b0);
        repeat (5) tick();
        checks++; if (err_count !== CW'(1)) begin failures++; $display("FAIL long_err_count: got %0d expected 1", err_count); end
        checks++; if (obs_q.size() != 0 || slots_full !== 2'b00) begin
            failures++;
            $display("FAIL long_no_stream: got %0d bins slots=%b expected 0/00", obs_q.size(), slots_full);
        end
        send_frame(NB, NB - 1, 7, 1'b1);
        wait_obs(NB, 400);
        checks++; if (first_cyc() != t_last + 2) begin failures++; $display("FAIL long_next_first_valid: got cyc %0d expected %0d", first_cyc(), t_last + 2); end
        checks++; if (obs_q.size() != NB || stream_mismatches() != 0) begin
            failures++;
            $display("FAIL long_next_data: got %0d bins %0d wrong expected %0d/0", obs_q.size(), stream_mismatches(), NB);
        end
        pulse_done();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL long_next_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_watchdog();
        int t;
        apply_reset();
        send_frame(NB, NB - 1, 8, 1'b1);
        t = t_last;
        wait_until(t + 1170);
        checks++; if (abort_cnt != 1) begin failures++; $display("FAIL wd_abort_count: got %0d pulses expected 1", abort_cnt); end
        checks++; if (abort_cyc != t + 1161) begin failures++; $display("FAIL wd_abort_cycle: got cyc %0d expected %0d", abort_cyc, t + 1161); end
        checks++; if (timeout_count !== CW'(1)) begin failures++; $display("FAIL wd_timeout_count: got %0d expected 1", timeout_count); end
        checks++; if (slots_full !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wd_slot_freed: got slots=%b busy=%0b expected 00/0", slots_full, busy);
        end
    endtask

    task automatic test_done_timeout_tie();
        int t;
        apply_reset();
        send_frame(NB, NB - 1, 9, 1'b1);
        t = t_last;
        wait_until(t + 1160);
        pulse_done();
        wait_until(t + 1170);
        checks++; if (abort_cnt != 0) begin failures++; $display("FAIL tie_no_abort: got %0d pulses expected 0", abort_cnt); end
        checks++; if (timeout_count !== '0) begin failures++; $display("FAIL tie_timeout_count: got %0d expected 0", timeout_count); end
        checks++; if (busy !== 1'b0 || slots_full !== 2'b00) begin
            failures++;
            $display("FAIL tie_final_state: got busy=%0b slots=%b expected 0/00", busy, slots_full);
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        send_frame(100, 99, 10, 1'b0);
        send_frame(NB, NB - 1, 11, 1'b1);
        wait_obs(80, 400);
        // The cycle now in progress carries bin 80.
        checks++; if (eng_valid !== 1'b1 || eng_data !== exp_q[80]) begin
            failures++;
            $display("FAIL midrst_pre_bin80: got valid=%0b data=%0h expected 1/%0h", eng_valid, eng_data, exp_q[80]);
        end
        rst = 1'b1;
        #1;
        checks++; if (eng_valid !== 1'b0 || eng_data !== '0) begin
            failures++;
            $display("FAIL midrst_async_drop: got valid=%0b data=%0h expected 0/0", eng_valid, eng_data);
        end
        checks++; if (err_count !== '0 || drop_count !== '0 || timeout_count !== '0 || slots_full !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_state: got err=%0d drop=%0d to=%0d slots=%b busy=%0b expected all 0",
                     err_count, drop_count, timeout_count, slots_full, busy);
        end
        tick();
        rst = 1'b0;
        tick();
        clear_sb();
        send_frame(NB, NB - 1, 12, 1'b1);
        wait_obs(NB, 400);
        checks++; if (first_cyc() != t_last + 2) begin failures++; $display("FAIL midrst_next_first_valid: got cyc %0d expected %0d", first_cyc(), t_last + 2); end
        checks++; if (obs_q.size() != NB || stream_mismatches() != 0) begin
            failures++;
            $display("FAIL midrst_next_data: got %0d bins %0d wrong expected %0d/0", obs_q.size(), stream_mismatches(), NB);
        end
        pulse_done();
        tick();
    endtask

    task automatic test_idle_data();
        checks++; if (idle_bad != 0) begin failures++; $display("FAIL idle_data_zero: got %0d nonzero idle samples expected 0", idle_bad); end
    endtask

    // ------------------------------------------------------------------
    // Sequence and final report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_short_frame();
        test_long_frame();
        test_watchdog();
        test_done_timeout_tie();
        test_reset_mid_burst();
        test_idle_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
